// File: rtl/seq_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// seq_pulse_gen_if
//
// Purpose:
//   Bundles the control inputs and strobe outputs of the sequential pulse
//   generator so that the block and its user connect through one port.
//
// Optional feature macro:
//   SEQ_PULSE_GAP_EN - adds the 'gap' count signal (blank cycles between
//                      channels).
//
// Signals:
//   start     - launch a sequence (only honoured when idle)
//   stop      - abort the sequence and return to idle
//   en        - advance enable; low pauses the running sequence in place
//   mode      - 0 = continuous, 1 = single pass
//   dir       - 0 = descending (top channel first), 1 = ascending
//   dwell     - cycles each channel is held (0 behaves like 1)
//   gap       - blank cycles between channels (macro builds only)
//   pulse_out - one-hot channel strobe, zero when not showing a channel
//   busy      - high while a sequence is active
//   wrap      - one-cycle marker on the final dwell cycle of a pass
//
// Modports:
//   master - the side that drives the controls (user / testbench)
//   slave  - the pulse generator itself
// -----------------------------------------------------------------------------
interface seq_pulse_gen_if #(
    parameter int N_CH    = 6,
    parameter int DWELL_W = 8
);

    logic               start;
    logic               stop;
    logic               en;
    logic               mode;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
`ifdef SEQ_PULSE_GAP_EN
    logic [DWELL_W-1:0] gap;
`endif
    logic [N_CH-1:0]    pulse_out;
    logic               busy;
    logic               wrap;

`ifdef SEQ_PULSE_GAP_EN
    modport master (
        output start, stop, en, mode, dir, dwell, gap,
        input  pulse_out, busy, wrap
    );

    modport slave (
        input  start, stop, en, mode, dir, dwell, gap,
        output pulse_out, busy, wrap
    );
`else
    modport master (
        output start, stop, en, mode, dir, dwell,
        input  pulse_out, busy, wrap
    );

    modport slave (
        input  start, stop, en, mode, dir, dwell,
        output pulse_out, busy, wrap
    );
`endif

endinterface

// File: rtl/seq_pulse_gen.sv
// -----------------------------------------------------------------------------
// seq_pulse_gen
//
// Purpose:
//   N-channel ring pulse generator. Exactly one output bit is high at a time
//   while running; the active bit steps through every channel in order and
//   each channel is held for a programmable number of cycles. The direction
//   and continuous/single-pass behaviour are chosen at launch.
//
// Optional feature macro:
//   SEQ_PULSE_GAP_EN - inserts 'gap' blank cycles (pulse_out = 0) between
//                      channels via an extra GAP state. Without the macro the
//                      channels run back-to-back.
//
// Parameters:
//   N_CH    - number of output channels (>= 2)
//   DWELL_W - width of the dwell and gap count inputs
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - seq_pulse_gen_if.slave: start/stop/en/mode/dir/dwell[/gap] in,
//           pulse_out/busy/wrap out (all outputs registered)
// -----------------------------------------------------------------------------
module seq_pulse_gen #(
    parameter int N_CH    = 6,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_pulse_gen_if.slave       bus
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);
    localparam logic [N_CH-1:0]    ONE_HOT  = N_CH'(1);

`ifdef SEQ_PULSE_GAP_EN
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        RUN
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] hold_q, hold_d;
    logic               mode_q, mode_d;
    logic               dir_q, dir_d;
`ifdef SEQ_PULSE_GAP_EN
    logic [DWELL_W-1:0] gap_q, gap_d;
    logic [DWELL_W-1:0] gcnt_q, gcnt_d;
`endif
    logic [N_CH-1:0]    pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;

    // Set when the displayed (channel, dwell cycle) position moves this edge;
    // wrap must only fire when we newly arrive at the final cycle, not while
    // a paused final cycle is being held.
    logic               stepped;

    // Last channel of a pass: bit 0 when descending, bit N_CH-1 when ascending.
    function automatic logic [IDX_W-1:0] last_idx(input logic asc);
        return asc ? LAST_IDX : '0;
    endfunction

    function automatic logic [IDX_W-1:0] first_idx(input logic asc);
        return asc ? '0 : LAST_IDX;
    endfunction

    // Explicit wrap at the range ends keeps non-power-of-two N_CH from ever
    // reaching an unused index code.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic             asc);
        if (asc) begin
            return (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
        end
        return (idx == '0) ? LAST_IDX : idx - IDX_ONE;
    endfunction

    // Next-state computation for the sequencer. The output registers are
    // derived from the next-state values so that pulse_out/busy/wrap line up
    // with the state they describe in the same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
`ifdef SEQ_PULSE_GAP_EN
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
`endif
        stepped = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
                    mode_d  = bus.mode;
                    dir_d   = bus.dir;
                    hold_d  = (bus.dwell == '0) ? CNT_ONE : bus.dwell;
                    idx_d   = first_idx(bus.dir);
                    cnt_d   = '0;
                    stepped = 1'b1;
`ifdef SEQ_PULSE_GAP_EN
                    gap_d   = bus.gap;
                    gcnt_d  = '0;
`endif
                end
            end

            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (bus.en) begin
                    stepped = 1'b1;
                    if (cnt_q == hold_q - CNT_ONE) begin
                        cnt_d = '0;
                        if (mode_q && (idx_q == last_idx(dir_q))) begin
                            // Single pass done: no trailing gap.
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            // The index advances on entry to GAP so the gap
                            // exit only has to flip back to RUN.
                            idx_d = next_idx(idx_q, dir_q);
`ifdef SEQ_PULSE_GAP_EN
                            if (gap_q != '0) begin
                                state_d = GAP;
                                gcnt_d  = '0;
                            end
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

`ifdef SEQ_PULSE_GAP_EN
            GAP: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                end else if (bus.en) begin
                    if (gcnt_q == gap_q - CNT_ONE) begin
                        state_d = RUN;
                        gcnt_d  = '0;
                        stepped = 1'b1;
                    end else begin
                        gcnt_d = gcnt_q + CNT_ONE;
                    end
                end
            end
`endif

            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        pulse_d = (state_d == RUN) ? (ONE_HOT << idx_d) : '0;
        busy_d  = (state_d != IDLE);
        wrap_d  = stepped && (state_d == RUN) &&
                  (idx_d == last_idx(dir_d)) && (cnt_d == hold_d - CNT_ONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= CNT_ONE;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
`ifdef SEQ_PULSE_GAP_EN
            gap_q   <= '0;
            gcnt_q  <= '0;
`endif
            pulse_q <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
`ifdef SEQ_PULSE_GAP_EN
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
`endif
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_seq_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pulse_gen
//
// Drives three generators (6, 5 and 4 channels) from one shared stimulus and
// compares each against a pass-position model on every falling edge, plus
// directed sequences with literal expectations. Honours SEQ_PULSE_GAP_EN.
// -----------------------------------------------------------------------------
module tb_seq_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic       start, stop, en, mode, dir;
    logic [7:0] dwellVal;
    logic [7:0] gapVal;

    int errors;
    int checks;
    bit scoreOn;

    seq_pulse_gen_if #(.N_CH(6), .DWELL_W(8)) if0 ();
    seq_pulse_gen_if #(.N_CH(5), .DWELL_W(8)) if1 ();
    seq_pulse_gen_if #(.N_CH(4), .DWELL_W(8)) if2 ();

    seq_pulse_gen #(.N_CH(6), .DWELL_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    seq_pulse_gen #(.N_CH(5), .DWELL_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    seq_pulse_gen #(.N_CH(4), .DWELL_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    assign if0.start = start; assign if1.start = start; assign if2.start = start;
    assign if0.stop  = stop;  assign if1.stop  = stop;  assign if2.stop  = stop;
    assign if0.en    = en;    assign if1.en    = en;    assign if2.en    = en;
    assign if0.mode  = mode;  assign if1.mode  = mode;  assign if2.mode  = mode;
    assign if0.dir   = dir;   assign if1.dir   = dir;   assign if2.dir   = dir;
    assign if0.dwell = dwellVal; assign if1.dwell = dwellVal; assign if2.dwell = dwellVal;
`ifdef SEQ_PULSE_GAP_EN
    assign if0.gap = gapVal; assign if1.gap = gapVal; assign if2.gap = gapVal;
`endif

    logic [7:0] actPulse [3];
    logic       actBusy  [3];
    logic       actWrap  [3];

    assign actPulse[0] = {2'b00, if0.pulse_out};
    assign actPulse[1] = {3'b000, if1.pulse_out};
    assign actPulse[2] = {4'b0000, if2.pulse_out};
    assign actBusy[0] = if0.busy; assign actBusy[1] = if1.busy; assign actBusy[2] = if2.busy;
    assign actWrap[0] = if0.wrap; assign actWrap[1] = if1.wrap; assign actWrap[2] = if2.wrap;

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int nch(input int k);
        return (k == 0) ? 6 : ((k == 1) ? 5 : 4);
    endfunction

    // Reference model: tracks position p within the pass (0 = first channel),
    // elapsed dwell cycles e and elapsed gap cycles g; the channel bit is
    // derived from p and the latched direction.
    bit         mActive [3];
    bit         mInGap  [3];
    int         mP      [3];
    int         mE      [3];
    int         mG      [3];
    int         mH      [3];
    int         mGapLen [3];
    bit         mMode   [3];
    bit         mDir    [3];
    logic [7:0] expPulse [3];
    logic       expBusy  [3];
    logic       expWrap  [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mActive[k]  = 0;
                mInGap[k]   = 0;
                expPulse[k] = 8'h00;
                expBusy[k]  = 1'b0;
                expWrap[k]  = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int  n;
                bit  fresh;
                bit  showing;
                n     = nch(k);
                fresh = 0;
                if (!mActive[k]) begin
                    if (start && !stop) begin
                        mActive[k] = 1;
                        mInGap[k]  = 0;
                        mP[k]      = 0;
                        mE[k]      = 0;
                        mMode[k]   = mode;
                        mDir[k]    = dir;
                        mH[k]      = (dwellVal == 8'd0) ? 1 : int'(dwellVal);
`ifdef SEQ_PULSE_GAP_EN
                        mGapLen[k] = int'(gapVal);
`else
                        mGapLen[k] = 0;
`endif
                        fresh = 1;
                    end
                end else if (stop) begin
                    mActive[k] = 0;
                    mInGap[k]  = 0;
                end else if (en) begin
                    if (mInGap[k]) begin
                        mG[k]++;
                        if (mG[k] == mGapLen[k]) begin
                            mInGap[k] = 0;
                            fresh     = 1;
                        end
                    end else begin
                        mE[k]++;
                        if (mE[k] == mH[k]) begin
                            mE[k] = 0;
                            if (mP[k] == n - 1 && mMode[k]) begin
                                mActive[k] = 0;
                            end else begin
                                mP[k] = (mP[k] + 1) % n;
                                if (mGapLen[k] > 0) begin
                                    mInGap[k] = 1;
                                    mG[k]     = 0;
                                end else begin
                                    fresh = 1;
                                end
                            end
                        end else begin
                            fresh = 1;
                        end
                    end
                end
                showing     = mActive[k] && !mInGap[k];
                expPulse[k] = showing ? (8'd1 << (mDir[k] ? mP[k] : (n - 1 - mP[k]))) : 8'h00;
                expBusy[k]  = mActive[k];
                expWrap[k]  = showing && fresh && (mP[k] == n - 1) && (mE[k] == mH[k] - 1);
            end
        end
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s inst%0d: got %0h expected %0h at %0t",
                     name, inst, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic sp, input logic e,
                                 input logic m, input logic d,
                                 input logic [7:0] dw, input logic [7:0] gp);
        start    = s;
        stop     = sp;
        en       = e;
        mode     = m;
        dir      = d;
        dwellVal = dw;
        gapVal   = gp;
    endtask

    // Continuous scoreboard: every falling edge, every instance.
    always @(negedge clk) begin
        if (scoreOn) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput("model_pulse", k, actPulse[k], expPulse[k]);
                checkOutput("model_busy",  k, {7'd0, actBusy[k]}, {7'd0, expBusy[k]});
                checkOutput("model_wrap",  k, {7'd0, actWrap[k]}, {7'd0, expWrap[k]});
            end
        end
    end

    // Return everything to idle with a one-cycle stop.
    task automatic goIdle();
        applyStimulus(0, 1, 1, 0, 0, 8'd1, 8'd0);
        @(negedge clk);
        applyStimulus(0, 0, 1, 0, 0, 8'd1, 8'd0);
        @(negedge clk);
    endtask

    logic [7:0] t1Exp  [7]  = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h20};
    logic [7:0] gapExp [11] = '{8'h8, 8'h8, 8'h0, 8'h4, 8'h4, 8'h0, 8'h2, 8'h2, 8'h0, 8'h1, 8'h1};

    initial begin
        errors  = 0;
        checks  = 0;
        scoreOn = 0;
        rst_n   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_pulse", k, actPulse[k], 8'h00);
            checkOutput("reset_busy",  k, {7'd0, actBusy[k]}, 8'h00);
            checkOutput("reset_wrap",  k, {7'd0, actWrap[k]}, 8'h00);
        end
        rst_n   = 1'b1;
        scoreOn = 1;
        @(negedge clk);

        // Continuous, descending, dwell 1.
        $display("[TB] continuous descending dwell=1");
        applyStimulus(1, 0, 1, 0, 0, 8'd1, 8'd0);
        @(negedge clk);
        start = 0;
        for (int c = 1; c <= 7; c++) begin
            checkOutput("t1_pulse", 0, actPulse[0], t1Exp[c-1]);
            checkOutput("t1_wrap",  0, {7'd0, actWrap[0]}, (c == 6) ? 8'd1 : 8'd0);
            checkOutput("t1_busy",  0, {7'd0, actBusy[0]}, 8'd1);
            @(negedge clk);
        end
        goIdle();

        // One-shot, ascending, dwell 3.
        $display("[TB] one-shot ascending dwell=3");
        applyStimulus(1, 0, 1, 1, 1, 8'd3, 8'd0);
        @(negedge clk);
        start = 0;
        for (int c = 1; c <= 19; c++) begin
            logic [7:0] want;
            want = (c <= 18) ? (8'd1 << ((c - 1) / 3)) : 8'h00;
            checkOutput("t2_pulse", 0, actPulse[0], want);
            checkOutput("t2_wrap",  0, {7'd0, actWrap[0]}, (c == 18) ? 8'd1 : 8'd0);
            checkOutput("t2_busy",  0, {7'd0, actBusy[0]}, (c <= 18) ? 8'd1 : 8'd0);
            @(negedge clk);
        end
        goIdle();

        // dwell 0 behaves as dwell 1.
        $display("[TB] dwell=0 and en pause");
        applyStimulus(1, 0, 1, 0, 0, 8'd0, 8'd0);
        @(negedge clk);
        start = 0;
        for (int c = 1; c <= 7; c++) begin
            checkOutput("t3_pulse", 0, actPulse[0], t1Exp[c-1]);
            @(negedge clk);
        end
        goIdle();

        // en low for 4 cycles while the first channel of a dwell-3 run shows.
        applyStimulus(1, 0, 1, 0, 0, 8'd3, 8'd0);
        @(negedge clk);
        start = 0;
        checkOutput("t3_first", 0, actPulse[0], 8'h20);
        en = 0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checkOutput("t3_frozen", 0, actPulse[0], 8'h20);
        end
        en = 1;
        @(negedge clk);
        checkOutput("t3_resume6", 0, actPulse[0], 8'h20);
        @(negedge clk);
        checkOutput("t3_resume7", 0, actPulse[0], 8'h20);
        @(negedge clk);
        checkOutput("t3_next", 0, actPulse[0], 8'h10);
        goIdle();

        // Five channels, dwell 2, continuous, stop at cycle 13.
        $display("[TB] five channels with stop");
        applyStimulus(1, 0, 1, 0, 0, 8'd2, 8'd0);
        @(negedge clk);
        start = 0;
        for (int c = 1; c <= 13; c++) begin
            checkOutput("t4_pulse", 1, actPulse[1], 8'd1 << (4 - ((c - 1) / 2) % 5));
            checkOutput("t4_wrap",  1, {7'd0, actWrap[1]}, (c == 10) ? 8'd1 : 8'd0);
            if (c == 13) stop = 1;
            @(negedge clk);
        end
        checkOutput("t4_stop_pulse", 1, actPulse[1], 8'h00);
        checkOutput("t4_stop_busy",  1, {7'd0, actBusy[1]}, 8'h00);
        start = 1;
        repeat (2) @(negedge clk);
        checkOutput("t4_startstop_busy", 1, {7'd0, actBusy[1]}, 8'h00);
        checkOutput("t4_startstop_busy", 0, {7'd0, actBusy[0]}, 8'h00);
        applyStimulus(0, 0, 1, 0, 0, 8'd1, 8'd0);
        @(negedge clk);

        // Asynchronous reset between edges in the middle of a dwell.
        $display("[TB] async reset mid-dwell");
        applyStimulus(1, 0, 1, 0, 1, 8'd4, 8'd0);
        @(negedge clk);
        start = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("rst_pulse", k, actPulse[k], 8'h00);
            checkOutput("rst_busy",  k, {7'd0, actBusy[k]}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 1, 0, 0, 8'd2, 8'd0);
        @(negedge clk);
        start = 0;
        checkOutput("rst_restart", 0, actPulse[0], 8'h20);
        checkOutput("rst_restart", 2, actPulse[2], 8'h08);
        goIdle();

`ifdef SEQ_PULSE_GAP_EN
        // Gap of 1 between channels, one-shot, descending, four channels.
        $display("[TB] gap one-shot");
        applyStimulus(1, 0, 1, 1, 0, 8'd2, 8'd1);
        @(negedge clk);
        start = 0;
        for (int c = 1; c <= 12; c++) begin
            checkOutput("gap_pulse", 2, actPulse[2], (c <= 11) ? gapExp[c-1] : 8'h00);
            checkOutput("gap_wrap",  2, {7'd0, actWrap[2]}, (c == 11) ? 8'd1 : 8'd0);
            checkOutput("gap_busy",  2, {7'd0, actBusy[2]}, (c <= 11) ? 8'd1 : 8'd0);
            @(negedge clk);
        end
        goIdle();
`endif

        // Randomised run checked by the model.
        $display("[TB] random stimulus");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 99) < 85),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 5)),
                          8'($urandom_range(0, 2)));
            @(negedge clk);
        end
        goIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
